// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake states, arbiter states and the
// latched request payload driven onto the RAM port.
package cpu_types_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned ARB_TIMEOUT = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2,
      HALTED = 2'd3
   } arb_state_t;

   // Operation captured when a requester is granted the RAM.
   typedef struct packed {
      logic  write;
      word_t addr;
      word_t store;
   } arb_req_t;

endpackage

// File: rtl/arb_timer.sv
// Grant-cycle counter: expired is high during the TIMEOUT-th consecutive
// enabled cycle since the last clear.
module arb_timer
   import cpu_types_pkg::*;
#(
   parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // Saturates at TIMEOUT so a stuck enable cannot wrap back to zero.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable && (cnt != CW'(TIMEOUT))) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = enable && (cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, data first.
// Optional performance counters are built when ARB_PERF_EN is defined.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        ihit,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dhit,
   input  logic        halt,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate,
`ifdef ARB_PERF_EN
   output logic [31:0] icount,
   output logic [31:0] dcount,
   output logic [31:0] stallcount,
`endif
   output logic        err
);

   arb_state_t state, state_next;
   arb_req_t   req_q, req_next;
   logic       latch;
   logic       set_err;
   logic       in_grant;
   logic       req_active;
   logic       expired;

   assign in_grant = (state == DGRANT) || (state == IGRANT);

   arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (CLK),
      .rst     (RST),
      .clear   (!in_grant),
      .enable  (in_grant),
      .expired (expired)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         req_q <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         if (latch)   req_q <= req_next;
         if (set_err) err   <= 1'b1;
      end
   end

   // Next state plus RAM/CPU-side outputs; hit and load follow ramstate in the same cycle.
   always_comb begin
      state_next = state;
      latch      = 1'b0;
      req_next   = '0;
      set_err    = 1'b0;
      req_active = 1'b0;
      ihit       = 1'b0;
      dhit       = 1'b0;
      iload      = '0;
      dload      = '0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;

      case (state)
         IDLE: begin
            if (halt) begin
               state_next = HALTED;
            end else if (dWEN || dREN) begin
               state_next = DGRANT;
               latch      = 1'b1;
               req_next   = '{write: dWEN, addr: daddr, store: dstore};
            end else if (iREN) begin
               state_next = IGRANT;
               latch      = 1'b1;
               req_next   = '{write: 1'b0, addr: iaddr, store: '0};
            end
         end

         DGRANT, IGRANT: begin
            ramREN     = !req_q.write;
            ramWEN     = req_q.write;
            ramaddr    = req_q.addr;
            ramstore   = req_q.store;
            req_active = (state == DGRANT) ? (dREN || dWEN) : iREN;

            if (ramstate == ERROR) begin
               set_err    = 1'b1;
               state_next = IDLE;
            end else if (!req_active) begin
               state_next = IDLE;
            end else if (ramstate == ACCESS) begin
               state_next = IDLE;
               if (state == DGRANT) begin
                  dhit  = 1'b1;
                  dload = ramload;
               end else begin
                  ihit  = 1'b1;
                  iload = ramload;
               end
            end else if (expired) begin
               set_err    = 1'b1;
               state_next = IDLE;
            end
         end

         HALTED: state_next = HALTED;

         default: state_next = IDLE;
      endcase
   end

`ifdef ARB_PERF_EN
   // Saturating event counters for completed accesses and stalled grant cycles.
   always_ff @(posedge CLK) begin
      if (RST) begin
         icount     <= '0;
         dcount     <= '0;
         stallcount <= '0;
      end else begin
         if (ihit && (icount != '1)) icount <= icount + 32'd1;
         if (dhit && (dcount != '1)) dcount <= dcount + 32'd1;
         if (in_grant && (ramstate != ACCESS) && (stallcount != '1))
            stallcount <= stallcount + 32'd1;
      end
   end
`endif

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: the maximum number of cycles in GRANT state before the arbiter aborts a transaction.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port iREN, input, 1 bit: instruction read request.
REQ-005 The block SHALL have port iaddr, input, 32 bits: instruction address.
REQ-006 The block SHALL have port iload, output, 32 bits: instruction read data.
REQ-007 The block SHALL have port ihit, output, 1 bit: one-cycle pulse that completes an instruction read.
REQ-008 The block SHALL have ports dREN and dWEN, input, 1 bit each: data read request and data write request.
REQ-009 The block SHALL have ports daddr and dstore, input, 32 bits each: data address and data write data.
REQ-010 The block SHALL have port dload, output, 32 bits: data read data.
REQ-011 The block SHALL have port dhit, output, 1 bit: one-cycle pulse that completes a data access.
REQ-012 The block SHALL have port halt, input, 1 bit: CPU halt request.
REQ-013 The block SHALL have ports ramREN and ramWEN, output, 1 bit each: RAM read strobe and RAM write strobe.
REQ-014 The block SHALL have ports ramaddr and ramstore, output, 32 bits each: RAM address and RAM write data.
REQ-015 The block SHALL have port ramload, input, 32 bits: RAM read data.
REQ-016 The block SHALL have port ramstate, input, ramstate_t: one of FREE, BUSY, ACCESS, ERROR.
REQ-017 The block SHALL have port err, output, 1 bit: sticky flag set on RAM ERROR or timeout.

Function
REQ-018 The FSM SHALL have states IDLE, DGRANT, IGRANT, HALTED.
REQ-019 In IDLE with no halt: if dWEN or dREN is high, the FSM SHALL move to DGRANT; otherwise, if iREN is high, to IGRANT; otherwise it SHALL stay in IDLE. Data requests have priority over instruction requests.
REQ-020 On entry to a GRANT state, the block SHALL latch the address, write data and operation; when dWEN and dREN are both high, the write wins.
REQ-021 In DGRANT and IGRANT, ramREN or ramWEN SHALL be driven from the latched operation, and ramaddr/ramstore from the latched values; ram outputs SHALL be 0 in IDLE and HALTED.
REQ-022 When ramstate==ACCESS in a GRANT state, the block SHALL pulse the matching hit signal for exactly that cycle, with iload/dload = ramload in the same cycle, and return to IDLE on the next edge.
REQ-023 Latency SHALL be: request seen in IDLE at edge N; strobes high from cycle N+1; hit in the first cycle with ACCESS; one IDLE cycle between back-to-back transactions.
REQ-024 If the granted requester drops its request before ACCESS, the block SHALL return to IDLE on the next edge with no hit and no err.
REQ-025 If ramstate==ERROR, or the grant-cycle counter reaches TIMEOUT, the block SHALL set err, return to IDLE without asserting hit, and keep err at 1 until RST.
REQ-026 When halt is high in IDLE, the FSM SHALL enter HALTED; halt asserted mid-transaction SHALL take effect only after that transaction completes.
REQ-027 In HALTED, the block SHALL ignore all requests; only RST exits HALTED.
REQ-028 While not hit, iload and dload SHALL be 0.

Reset
REQ-029 On RST, the FSM SHALL go to IDLE and all outputs, latches, the counter and err SHALL be 0 on the following cycle.
REQ-030 RST during a GRANT state SHALL abort the transaction with no hit pulse.

Configuration
REQ-031 When ARB_PERF_EN is defined, the block SHALL add 32-bit saturating outputs icount, dcount and stallcount: completed instruction reads, completed data accesses, and GRANT cycles without ACCESS, all cleared by RST.
REQ-032 When ARB_PERF_EN is undefined, those ports and counters SHALL be absent and the remaining behaviour SHALL be unchanged.

Structure
REQ-033 arb_state_t and the default TIMEOUT SHALL live in cpu_types_pkg, alongside the existing ramstate_t.
REQ-034 The timeout counter SHALL be a sub-module, arb_timer, with clear, enable and expired ports.

Verification
REQ-035 Instruction read: iREN=1, iaddr=0x40, ramstate=ACCESS after 2 BUSY cycles, ramload=0x8C220004 -> ihit pulses once, iload=0x8C220004, ramREN high for 3 cycles.
REQ-036 Priority: iREN=1 and dREN=1 at the same edge, daddr=0x100 -> DGRANT first, dhit, one IDLE cycle, then IGRANT and ihit.
REQ-037 Write vs read: dWEN=1 and dREN=1, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dhit on ACCESS.
REQ-038 Timeout: ramstate stays BUSY for 16 cycles -> err=1, no hit, return to IDLE; err stays 1 until RST.
REQ-039 Halt: halt=1 mid-transaction -> transaction completes with hit, then HALTED; later iREN=1 gives no strobes; RST returns to IDLE with all outputs 0.
